// File: rtl/bytewrite_data_ram.sv
// Word-organised single-port data RAM with byte write strobes and a registered read port.
// Optional macro BYTEWRITE_RAM_ADDR_CHECK_EN adds an out-of-range access flag (addr_err_o).
module bytewrite_data_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 1024
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    en_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH/8-1:0] we_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
`ifdef BYTEWRITE_RAM_ADDR_CHECK_EN
  output logic                    addr_err_o,
`endif
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int unsigned NUM_BYTES   = DATA_WIDTH / 8;
  localparam int unsigned IDX_W       = $clog2(MEM_WORDS);
  localparam int unsigned BYTE_ADDR_W = IDX_W + 2;

  logic [DATA_WIDTH-1:0] RAM [MEM_WORDS];

  logic [IDX_W-1:0]      idx_c;
  logic                  oob_c;
  logic                  wr_en_c;
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
  logic                  unused_addr_bits;

  // Lane offset and bits above the array are intentionally ignored when wrapping.
  assign unused_addr_bits = ^addr_i;
  assign idx_c            = addr_i[BYTE_ADDR_W-1:2];

`ifdef BYTEWRITE_RAM_ADDR_CHECK_EN
  assign oob_c = (addr_i >> BYTE_ADDR_W) != '0;
`else
  assign oob_c = 1'b0;
`endif

  // Writes are blocked during reset and for rejected out-of-range accesses.
  assign wr_en_c = en_i & rstn_i & ~oob_c;

  always_ff @(posedge clk_i) begin : ram_write
    if (wr_en_c) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (we_i[k]) begin
          RAM[idx_c][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Read-first: the registered word is the array content before this edge's write.
  always_comb begin : read_next
    rdata_d = rdata_q;
    if (en_i) begin
      rdata_d = oob_c ? '0 : RAM[idx_c];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin : read_reg
    if (!rstn_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

`ifdef BYTEWRITE_RAM_ADDR_CHECK_EN
  logic addr_err_d, addr_err_q;

  assign addr_err_d = en_i & oob_c;

  always_ff @(posedge clk_i or negedge rstn_i) begin : err_reg
    if (!rstn_i) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= addr_err_d;
    end
  end

  assign addr_err_o = addr_err_q;
`endif

endmodule

// File: tb/tb_bytewrite_data_ram.sv
// Bench for bytewrite_data_ram: vector table fed through a scoreboard queue,
// plus hand-written reset and array-content sequences.
module tb_bytewrite_data_ram;

  logic        clk    = 1'b0;
  logic        rstn   = 1'b1;
  logic        en     = 1'b0;
  logic [31:0] addr   = '0;
  logic [3:0]  we     = '0;
  logic [31:0] wdata  = '0;
  logic [31:0] rdata;
`ifdef BYTEWRITE_RAM_ADDR_CHECK_EN
  logic        addr_err;
`endif

  int checks = 0;
  int errors = 0;

  bytewrite_data_ram #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .MEM_WORDS (1024)
  ) dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .en_i      (en),
    .addr_i    (addr),
    .we_i      (we),
    .wdata_i   (wdata),
`ifdef BYTEWRITE_RAM_ADDR_CHECK_EN
    .addr_err_o(addr_err),
`endif
    .rdata_o   (rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(logic e, logic [31:0] a, logic [3:0] w, logic [31:0] d,
                              logic c, logic [31:0] x, logic r);
    vec_t v;
    v.en = e; v.addr = a; v.we = w; v.wd = d; v.chk = c; v.exp = x; v.err = r;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Drive one vector, queue its expectation, compare once the read register updates.
  task automatic apply(input vec_t v, input int n);
    vec_t e;
    @(negedge clk);
    en = v.en; addr = v.addr; we = v.we; wdata = v.wd;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.chk) check($sformatf("vec%0d_rdata", n), rdata, e.exp);
`ifdef BYTEWRITE_RAM_ADDR_CHECK_EN
    check($sformatf("vec%0d_addr_err", n), {31'b0, addr_err}, {31'b0, e.err});
`endif
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : test
    logic [31:0] wrap_exp, ram0_exp;

`ifdef BYTEWRITE_RAM_ADDR_CHECK_EN
    wrap_exp = 32'd0;   // rejected access returns 0, RAM[0] untouched
    ram0_exp = 32'd13;
`else
    wrap_exp = 32'd13;  // read-first of RAM[0] before the wrapped write
    ram0_exp = 32'd42;
`endif

    // en, addr, we, wdata, check, expected rdata, expected addr_err
    tbl.push_back(mk(1, 32'd0,    4'hF, 32'd13,        0, 32'h0,        0));
    tbl.push_back(mk(1, 32'd4,    4'hF, 32'd13,        0, 32'h0,        0));
    tbl.push_back(mk(1, 32'd0,    4'h0, 32'h0,         1, 32'd13,       0));
    tbl.push_back(mk(1, 32'd4,    4'h0, 32'h0,         1, 32'd13,       0));
    tbl.push_back(mk(1, 32'd8,    4'hF, 32'h0,         0, 32'h0,        0));
    tbl.push_back(mk(1, 32'd8,    4'h4, 32'hAABBCCDD,  1, 32'h0,        0));
    tbl.push_back(mk(1, 32'd8,    4'h1, 32'h00000011,  1, 32'h00BB0000, 0));
    tbl.push_back(mk(1, 32'd8,    4'h0, 32'h0,         1, 32'h00BB0011, 0));
    tbl.push_back(mk(1, 32'd12,   4'hF, 32'd5,         0, 32'h0,        0));
    tbl.push_back(mk(1, 32'd12,   4'hF, 32'd9,         1, 32'd5,        0));
    tbl.push_back(mk(1, 32'd12,   4'h0, 32'h0,         1, 32'd9,        0));
    tbl.push_back(mk(0, 32'd0,    4'hF, 32'hFFFFFFFF,  1, 32'd9,        0));
    tbl.push_back(mk(1, 32'd0,    4'h0, 32'h0,         1, 32'd13,       0));
    tbl.push_back(mk(1, 32'd20,   4'hF, 32'h0,         0, 32'h0,        0));
    tbl.push_back(mk(1, 32'd20,   4'hC, 32'h12345678,  1, 32'h0,        0));
    tbl.push_back(mk(1, 32'd20,   4'h3, 32'hCAFEBABE,  1, 32'h12340000, 0));
    tbl.push_back(mk(1, 32'd23,   4'h0, 32'h0,         1, 32'h1234BABE, 0));
`ifdef BYTEWRITE_RAM_ADDR_CHECK_EN
    tbl.push_back(mk(1, 32'd4096, 4'hF, 32'd42,        1, wrap_exp,     1));
`else
    tbl.push_back(mk(1, 32'd4096, 4'hF, 32'd42,        1, wrap_exp,     0));
`endif
    tbl.push_back(mk(1, 32'd0,    4'h0, 32'h0,         1, ram0_exp,     0));

    // Asynchronous reset before any clock edge
    #1 rstn = 1'b0;
    #1 check("reset_rdata", rdata, 32'h0);
`ifdef BYTEWRITE_RAM_ADDR_CHECK_EN
    check("reset_addr_err", {31'b0, addr_err}, 32'h0);
`endif
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    check("ram0", dut.RAM[0], ram0_exp);
    check("ram1", dut.RAM[1], 32'd13);
    check("ram2", dut.RAM[2], 32'h00BB0011);
    check("ram3", dut.RAM[3], 32'd9);
    check("ram5", dut.RAM[5], 32'h1234BABE);

    // Reset mid-cycle: rdata clears immediately, writes held off while low
    apply(mk(1, 32'd16, 4'hF, 32'd7, 0, 32'h0, 0), 100);
    apply(mk(1, 32'd16, 4'h0, 32'h0, 1, 32'd7, 0), 101);
    #2 rstn = 1'b0;
    #1 check("midreset_rdata", rdata, 32'h0);
    @(negedge clk);
    en = 1'b1; addr = 32'd16; we = 4'hF; wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 check("inreset_rdata_hold0", rdata, 32'h0);
    check("inreset_no_write", dut.RAM[4], 32'd7);
    @(negedge clk);
    en = 1'b0; we = 4'h0;
    rstn = 1'b1;
    apply(mk(1, 32'd16, 4'h0, 32'h0, 1, 32'd7, 0), 102);
    apply(mk(0, 32'd4,  4'hF, 32'h0, 1, 32'd7, 0), 103);
    apply(mk(1, 32'd4,  4'h0, 32'h0, 1, 32'd13, 0), 104);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
